// File: rtl/mcu_target_mux_pkg.sv
// Shared definitions for the MCU-to-target byte multiplexer: target ids,
// internal system-target command codes, reply constants and the frame FSM states.
package mcu_pkg;

    localparam int unsigned NUM_TGT = 4;

    localparam logic [7:0] ID_SYS  = 8'h00;
    localparam logic [7:0] ID_TGT1 = 8'h01;
    localparam logic [7:0] ID_TGT2 = 8'h02;
    localparam logic [7:0] ID_TGT3 = 8'h03;

    localparam logic [7:0] CMD_VERSION      = 8'h00;
    localparam logic [7:0] CMD_READ_PENDING = 8'h01;
    localparam logic [7:0] CMD_CLEAR        = 8'h02;
    localparam logic [7:0] CMD_WRITE_MASK   = 8'h03;
    localparam logic [7:0] CMD_READ_MASK    = 8'h04;

    localparam logic [7:0] VERSION_BYTE  = 8'hA5;
    localparam logic [7:0] VERSION_AFTER = 8'h01;
    localparam logic [7:0] REPLY_DROP    = 8'hFF;
    localparam logic [7:0] REPLY_NONE    = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DROP = 2'd3
    } mux_state_e;

    // Ids 1..3 are real targets; 0 is the internal system target, >= 4 is dropped.
    function automatic logic is_external(input logic [7:0] id);
        return (id == ID_TGT1) || (id == ID_TGT2) || (id == ID_TGT3);
    endfunction

endpackage

// File: rtl/mcu_target_mux_if.sv
// Bundle of the MCU link and target bus signals. The slave modport is the
// multiplexer's view; the master modport is the surrounding MCU/targets view.
interface mcu_target_mux_if;
    logic        mcu_strobe;
    logic        mcu_start;
    logic [7:0]  mcu_din;
    logic [7:0]  mcu_dout;
    logic        mcu_irq;
    logic [3:0]  tgt_strobe;
    logic        tgt_start;
    logic [7:0]  tgt_din;
    logic [31:0] tgt_dout;
    logic [3:0]  tgt_irq;
    logic [3:0]  tgt_iack;

    modport slave (
        input  mcu_strobe, mcu_start, mcu_din, tgt_dout, tgt_irq,
        output mcu_dout, mcu_irq, tgt_strobe, tgt_start, tgt_din, tgt_iack
    );

    modport master (
        output mcu_strobe, mcu_start, mcu_din, tgt_dout, tgt_irq,
        input  mcu_dout, mcu_irq, tgt_strobe, tgt_start, tgt_din, tgt_iack
    );
endinterface

// File: rtl/mcu_target_mux_irq_ctrl.sv
// Interrupt controller: rising-edge detect on target irq lines, pending bits,
// optional mask (MCU_IRQ_MASK_EN), acknowledge pulses and the MCU interrupt.
module mcu_irq_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] tgt_irq,
    input  logic       clr_en,
    input  logic [3:0] clr_bits,
`ifdef MCU_IRQ_MASK_EN
    input  logic       mask_we,
    input  logic [3:0] mask_wdata,
    output logic [3:0] mask,
`endif
    output logic [3:0] pending,
    output logic [3:0] tgt_iack,
    output logic       mcu_irq
);

    logic [3:0] irq_prev_q;
    logic [3:0] pending_q, pending_d;
    logic [3:0] iack_q, iack_d;
    logic       mcu_irq_q, mcu_irq_d;
    logic [3:0] mask_d;
    logic [3:0] rise;
    logic [3:0] clr;

    // Next-state for pending/ack/irq; a new edge overrides a same-cycle clear.
    always_comb begin
        rise      = tgt_irq & ~irq_prev_q;
        clr       = clr_en ? clr_bits : 4'h0;
        pending_d = (pending_q & ~clr) | rise;
        iack_d    = clr;
`ifdef MCU_IRQ_MASK_EN
        mask_d    = mask_we ? mask_wdata : mask;
`else
        mask_d    = 4'hF;
`endif
        mcu_irq_d = |(pending_d & mask_d);
    end

    // Register edge-detect history, pending bits, ack pulses and interrupt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_prev_q <= 4'h0;
            pending_q  <= 4'h0;
            iack_q     <= 4'h0;
            mcu_irq_q  <= 1'b0;
        end else begin
            irq_prev_q <= tgt_irq;
            pending_q  <= pending_d;
            iack_q     <= iack_d;
            mcu_irq_q  <= mcu_irq_d;
        end
    end

`ifdef MCU_IRQ_MASK_EN
    logic [3:0] mask_q;

    // Mask register, all sources enabled out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= 4'hF;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign mask = mask_q;
`endif

    assign pending  = pending_q;
    assign tgt_iack = iack_q;
    assign mcu_irq  = mcu_irq_q;

endmodule

// File: rtl/mcu_target_mux.sv
// MCU-to-target byte multiplexer. Frames are {id, command, payload...}; ids
// 1..3 are forwarded one clock later, id 0 is the internal system target and
// ids >= 4 are swallowed. Optional feature macro: MCU_IRQ_MASK_EN (mask
// write/read commands for the interrupt controller).
import mcu_pkg::*;

module mcu_target_mux #(
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic           clk,
    input  logic           reset_n,
    mcu_target_mux_if.slave bus
);

    mux_state_e  state_q, state_d;
    logic [7:0]  id_q, id_d;
    logic [7:0]  cmd_q, cmd_d;
    logic        first_q, first_d;
    logic [15:0] idle_cnt_q, idle_cnt_d;
    logic [7:0]  mcu_dout_q, mcu_dout_d;
    logic [3:0]  tgt_strobe_q, tgt_strobe_d;
    logic        tgt_start_q, tgt_start_d;
    logic [7:0]  tgt_din_q, tgt_din_d;

    logic [7:0]  eff_id;
    logic [7:0]  ext_reply;
    logic [7:0]  int_reply;
    logic        clr_en;
    logic [3:0]  pending;
`ifdef MCU_IRQ_MASK_EN
    logic        mask_we;
    logic [3:0]  mask;
`endif

    // Frame decode, reply selection, forwarding and idle timeout.
    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        cmd_d        = cmd_q;
        first_d      = first_q;
        idle_cnt_d   = idle_cnt_q;
        mcu_dout_d   = mcu_dout_q;
        tgt_strobe_d = 4'h0;
        tgt_start_d  = 1'b0;
        tgt_din_d    = tgt_din_q;
        clr_en       = 1'b0;
`ifdef MCU_IRQ_MASK_EN
        mask_we      = 1'b0;
`endif

        eff_id    = bus.mcu_start ? bus.mcu_din : id_q;
        ext_reply = bus.tgt_dout[{eff_id[1:0], 3'b000} +: 8];

        int_reply = REPLY_NONE;
        if (state_q == ST_DATA && !bus.mcu_start) begin
            case (cmd_q)
                CMD_VERSION:      int_reply = first_q ? VERSION_BYTE : VERSION_AFTER;
                CMD_READ_PENDING: int_reply = {4'h0, pending};
`ifdef MCU_IRQ_MASK_EN
                CMD_READ_MASK:    int_reply = {4'h0, mask};
`endif
                default:          int_reply = REPLY_NONE;
            endcase
        end

        if (bus.mcu_strobe) begin
            idle_cnt_d = 16'h0;
            if (bus.mcu_start || state_q != ST_IDLE) begin
                if (eff_id >= 8'd4) begin
                    mcu_dout_d = REPLY_DROP;
                end else if (eff_id == ID_SYS) begin
                    mcu_dout_d = int_reply;
                end else begin
                    mcu_dout_d = ext_reply;
                end
            end

            if (bus.mcu_start) begin
                state_d = ST_CMD;
                id_d    = bus.mcu_din;
                first_d = 1'b1;
            end else begin
                case (state_q)
                    ST_CMD: begin
                        cmd_d   = bus.mcu_din;
                        first_d = 1'b1;
                        state_d = (id_q >= 8'd4) ? ST_DROP : ST_DATA;
                        if (is_external(id_q)) begin
                            tgt_strobe_d[id_q[1:0]] = 1'b1;
                            tgt_start_d             = 1'b1;
                            tgt_din_d               = bus.mcu_din;
                        end
                    end
                    ST_DATA: begin
                        first_d = 1'b0;
                        if (is_external(id_q)) begin
                            tgt_strobe_d[id_q[1:0]] = 1'b1;
                            tgt_din_d               = bus.mcu_din;
                        end else if (id_q == ID_SYS && first_q) begin
                            clr_en = (cmd_q == CMD_CLEAR);
`ifdef MCU_IRQ_MASK_EN
                            mask_we = (cmd_q == CMD_WRITE_MASK);
`endif
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end else if (state_q != ST_IDLE) begin
            if (idle_cnt_q != 16'hFFFF) begin
                idle_cnt_d = idle_cnt_q + 16'd1;
            end
            if (idle_cnt_d >= TIMEOUT) begin
                state_d = ST_IDLE;
            end
        end
    end

    // Frame state machine and registered outputs toward MCU and targets.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            id_q         <= 8'h00;
            cmd_q        <= 8'h00;
            first_q      <= 1'b0;
            idle_cnt_q   <= 16'h0;
            mcu_dout_q   <= 8'h00;
            tgt_strobe_q <= 4'h0;
            tgt_start_q  <= 1'b0;
            tgt_din_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            cmd_q        <= cmd_d;
            first_q      <= first_d;
            idle_cnt_q   <= idle_cnt_d;
            mcu_dout_q   <= mcu_dout_d;
            tgt_strobe_q <= tgt_strobe_d;
            tgt_start_q  <= tgt_start_d;
            tgt_din_q    <= tgt_din_d;
        end
    end

    mcu_irq_ctrl u_irq_ctrl (
        .clk        (clk),
        .reset_n    (reset_n),
        .tgt_irq    (bus.tgt_irq),
        .clr_en     (clr_en),
        .clr_bits   (bus.mcu_din[3:0]),
`ifdef MCU_IRQ_MASK_EN
        .mask_we    (mask_we),
        .mask_wdata (bus.mcu_din[3:0]),
        .mask       (mask),
`endif
        .pending    (pending),
        .tgt_iack   (bus.tgt_iack),
        .mcu_irq    (bus.mcu_irq)
    );

    assign bus.mcu_dout   = mcu_dout_q;
    assign bus.tgt_strobe = tgt_strobe_q;
    assign bus.tgt_start  = tgt_start_q;
    assign bus.tgt_din    = tgt_din_q;

endmodule

// File: tb/tb_mcu_target_mux.sv
// Scoreboard bench for mcu_target_mux: stimulus pushes expected per-strobe
// responses, a negedge monitor pops and compares. Honours MCU_IRQ_MASK_EN.
module tb_mcu_target_mux;

    localparam logic [15:0] TO = 16'd40;

    typedef struct {
        logic [3:0] stb;
        logic       tstart;
        logic [7:0] tdin;
        logic       dchk;
        logic [7:0] dout;
    } exp_t;

    logic clk;
    logic reset_n;
    logic stb_seen;
    logic [3:0] irq_with_strobe;
    exp_t sb_q[$];
    logic [3:0] iack_exp_q[$];
    exp_t mon_e;
    logic [3:0] mon_iack;
    int n_checks;
    int n_fail;

    mcu_target_mux_if bus();

    mcu_target_mux #(.TIMEOUT(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Remember whether the MCU presented a byte at the last rising edge.
    always @(posedge clk) stb_seen <= bus.mcu_strobe;

    // Monitor: compare the registered response one clock after each strobe.
    always @(negedge clk) begin
        if (stb_seen === 1'b1) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL sb_underflow: strobe seen with no expected entry");
            end else begin
                mon_e = sb_q.pop_front();
                if (bus.tgt_strobe !== mon_e.stb ||
                    (mon_e.stb != 4'h0 && (bus.tgt_start !== mon_e.tstart || bus.tgt_din !== mon_e.tdin))) begin
                    n_fail++;
                    $display("[TB] FAIL fwd: got stb=%b start=%b din=%h, want stb=%b start=%b din=%h",
                             bus.tgt_strobe, bus.tgt_start, bus.tgt_din, mon_e.stb, mon_e.tstart, mon_e.tdin);
                end
                if (mon_e.dchk) begin
                    n_checks++;
                    if (bus.mcu_dout !== mon_e.dout) begin
                        n_fail++;
                        $display("[TB] FAIL mcu_dout: got %h, want %h", bus.mcu_dout, mon_e.dout);
                    end
                end
            end
        end else begin
            n_checks++;
            if (bus.tgt_strobe !== 4'h0) begin
                n_fail++;
                $display("[TB] FAIL spurious_strobe: got %b, want 0000", bus.tgt_strobe);
            end
        end
        if (bus.tgt_iack !== 4'h0) begin
            n_checks++;
            if (iack_exp_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL unexpected_iack: got %b, want 0000", bus.tgt_iack);
            end else begin
                mon_iack = iack_exp_q.pop_front();
                if (bus.tgt_iack !== mon_iack) begin
                    n_fail++;
                    $display("[TB] FAIL iack: got %b, want %b", bus.tgt_iack, mon_iack);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic [7:0] din, input logic [3:0] exp_stb,
                                 input logic exp_tstart, input logic dchk, input logic [7:0] exp_dout);
        exp_t e;
        e.stb = exp_stb; e.tstart = exp_tstart; e.tdin = din; e.dchk = dchk; e.dout = exp_dout;
        sb_q.push_back(e);
        @(negedge clk);
        bus.mcu_strobe = 1'b1;
        bus.mcu_start  = start;
        bus.mcu_din    = din;
        bus.tgt_irq    = bus.tgt_irq | irq_with_strobe;
        irq_with_strobe = 4'h0;
        @(negedge clk);
        bus.mcu_strobe = 1'b0;
        bus.mcu_start  = 1'b0;
    endtask

    // Three-byte internal-target frame with a checked payload reply.
    task automatic sysFrame(input logic [7:0] cmd, input logic [7:0] pay, input logic [7:0] exp_dout);
        applyStimulus(1'b1, 8'h00, 4'h0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, cmd,   4'h0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, pay,   4'h0, 1'b0, 1'b1, exp_dout);
    endtask

    task automatic waitDrain();
        int i;
        for (i = 0; i < 50 && (sb_q.size() != 0 || iack_exp_q.size() != 0); i++) @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0 || iack_exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL drain: got %0d/%0d pending entries, want 0/0", sb_q.size(), iack_exp_q.size());
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, want $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_checks = 0; n_fail = 0;
        irq_with_strobe = 4'h0;
        bus.mcu_strobe = 1'b0; bus.mcu_start = 1'b0; bus.mcu_din = 8'h00;
        bus.tgt_dout = 32'h3377_4299; bus.tgt_irq = 4'h0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        checkOutput("rst_mcu_dout", bus.mcu_dout, 8'h00);
        checkOutput("rst_mcu_irq", bus.mcu_irq, 1'b0);
        checkOutput("rst_tgt_strobe", bus.tgt_strobe, 4'h0);
        checkOutput("rst_tgt_start", bus.tgt_start, 1'b0);
        checkOutput("rst_tgt_din", bus.tgt_din, 8'h00);
        checkOutput("rst_tgt_iack", bus.tgt_iack, 4'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] forward to target 1");
        applyStimulus(1'b1, 8'h01, 4'h0,    1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 8'h03, 4'b0010, 1'b1, 1'b1, 8'h42);
        applyStimulus(1'b0, 8'h00, 4'b0010, 1'b0, 1'b1, 8'h42);
        applyStimulus(1'b0, 8'h5A, 4'b0010, 1'b0, 1'b1, 8'h42);

        $display("[TB] target 2 with idle timeout");
        applyStimulus(1'b1, 8'h02, 4'h0,    1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 8'h10, 4'b0100, 1'b1, 1'b1, 8'h77);
        repeat (int'(TO) - 10) @(negedge clk);
        applyStimulus(1'b0, 8'hAB, 4'b0100, 1'b0, 1'b1, 8'h77);
        repeat (int'(TO) + 5) @(negedge clk);
        applyStimulus(1'b0, 8'hCD, 4'h0,    1'b0, 1'b1, 8'h77);

        $display("[TB] dropped ids and target 3");
        applyStimulus(1'b1, 8'h07, 4'h0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 8'h55, 4'h0, 1'b0, 1'b1, 8'hFF);
        applyStimulus(1'b0, 8'h66, 4'h0, 1'b0, 1'b1, 8'hFF);
        applyStimulus(1'b1, 8'h04, 4'h0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 8'h01, 4'h0, 1'b0, 1'b1, 8'hFF);
        applyStimulus(1'b1, 8'h03, 4'h0,    1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 8'h01, 4'b1000, 1'b1, 1'b1, 8'h33);
        applyStimulus(1'b0, 8'h02, 4'b1000, 1'b0, 1'b1, 8'h33);

        $display("[TB] version command");
        applyStimulus(1'b1, 8'h00, 4'h0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 8'h11, 4'h0, 1'b0, 1'b1, 8'hA5);
        applyStimulus(1'b0, 8'h22, 4'h0, 1'b0, 1'b1, 8'h01);
        applyStimulus(1'b0, 8'h33, 4'h0, 1'b0, 1'b1, 8'h01);
        waitDrain();

        $display("[TB] interrupt on target 2");
        checkOutput("irq_idle", bus.mcu_irq, 1'b0);
        @(negedge clk); bus.tgt_irq[2] = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("irq_t2_set", bus.mcu_irq, 1'b1);
        sysFrame(8'h01, 8'h00, 8'h04);
        iack_exp_q.push_back(4'b0100);
        sysFrame(8'h02, 8'h04, 8'h00);
        waitDrain();
        checkOutput("irq_t2_clr", bus.mcu_irq, 1'b0);
        bus.tgt_irq[2] = 1'b0;

        $display("[TB] set wins over clear");
        @(negedge clk); bus.tgt_irq[3] = 1'b1;
        repeat (3) @(negedge clk); bus.tgt_irq[3] = 1'b0;
        repeat (2) @(negedge clk);
        applyStimulus(1'b1, 8'h00, 4'h0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 8'h02, 4'h0, 1'b0, 1'b0, 8'h00);
        irq_with_strobe = 4'b1000;
        iack_exp_q.push_back(4'b1000);
        applyStimulus(1'b0, 8'h08, 4'h0, 1'b0, 1'b1, 8'h00);
        sysFrame(8'h01, 8'h00, 8'h08);
        waitDrain();
        checkOutput("irq_t3_kept", bus.mcu_irq, 1'b1);
        iack_exp_q.push_back(4'b1000);
        sysFrame(8'h02, 8'h08, 8'h00);
        waitDrain();
        checkOutput("irq_t3_clr", bus.mcu_irq, 1'b0);
        bus.tgt_irq[3] = 1'b0;

`ifdef MCU_IRQ_MASK_EN
        $display("[TB] interrupt mask");
        sysFrame(8'h03, 8'h00, 8'h00);
        waitDrain();
        bus.tgt_irq[1] = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("irq_masked", bus.mcu_irq, 1'b0);
        sysFrame(8'h01, 8'h00, 8'h02);
        sysFrame(8'h04, 8'h00, 8'h00);
        sysFrame(8'h03, 8'h0F, 8'h00);
        waitDrain();
        repeat (2) @(negedge clk);
        checkOutput("irq_unmasked", bus.mcu_irq, 1'b1);
        sysFrame(8'h04, 8'h00, 8'h0F);
`else
        $display("[TB] mask commands inert");
        sysFrame(8'h03, 8'h00, 8'h00);
        waitDrain();
        bus.tgt_irq[1] = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("irq_nomask", bus.mcu_irq, 1'b1);
        sysFrame(8'h04, 8'h00, 8'h00);
`endif
        iack_exp_q.push_back(4'b0010);
        sysFrame(8'h02, 8'h02, 8'h00);
        waitDrain();
        checkOutput("irq_t1_clr", bus.mcu_irq, 1'b0);
        bus.tgt_irq[1] = 1'b0;

        $display("[TB] reset during data phase");
        @(negedge clk); bus.tgt_irq[1] = 1'b1;
        repeat (3) @(negedge clk); bus.tgt_irq[1] = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("irq_before_rst", bus.mcu_irq, 1'b1);
        applyStimulus(1'b1, 8'h01, 4'h0,    1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 8'h03, 4'b0010, 1'b1, 1'b1, 8'h42);
        applyStimulus(1'b0, 8'h11, 4'b0010, 1'b0, 1'b1, 8'h42);
        waitDrain();
        #2 reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_mcu_dout", bus.mcu_dout, 8'h00);
        checkOutput("mid_rst_mcu_irq", bus.mcu_irq, 1'b0);
        checkOutput("mid_rst_tgt_din", bus.tgt_din, 8'h00);
        checkOutput("mid_rst_tgt_start", bus.tgt_start, 1'b0);
        checkOutput("mid_rst_tgt_strobe", bus.tgt_strobe, 4'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(1'b0, 8'h77, 4'h0, 1'b0, 1'b1, 8'h00);
        sysFrame(8'h01, 8'h00, 8'h00);
        waitDrain();
        checkOutput("post_rst_irq", bus.mcu_irq, 1'b0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mcu_target_mux.md
MCU_TARGET_MUX -- requirements
Module: mcu_target_mux

Interface
REQ-001 Parameter: TIMEOUT, 16'd50000, idle clk cycles inside a frame before forced return to IDLE.
REQ-002 clk  in  1  system clock; all logic rising-edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 mcu_strobe  in  1  one-cycle pulse, byte valid from MCU link.
REQ-005 mcu_start  in  1  qualifies mcu_strobe; byte is first of frame.
REQ-006 mcu_din  in  8  byte from MCU.
REQ-007 mcu_dout  out  8  byte returned to MCU.
REQ-008 mcu_irq  out  1  level interrupt to MCU.
REQ-009 tgt_strobe  out  4  per-target byte strobe; bit n = target n.
REQ-010 tgt_start  out  1  shared; marks a target's command byte.
REQ-011 tgt_din  out  8  shared byte to targets.
REQ-012 tgt_dout  in  32  target n reply on bits [8n+7:8n].
REQ-013 tgt_irq  in  4  per-target interrupt request (level).
REQ-014 tgt_iack  out  4  per-target one-cycle acknowledge pulse.

Function
REQ-015 Frame format: byte 0 (mcu_start=1) = target id; byte 1 = command; bytes 2+ = payload.
REQ-016 States: IDLE, CMD, DATA, DROP; any mcu_strobe with mcu_start=1 enters CMD and latches id from any state.
REQ-017 CMD: next strobe forwards byte with tgt_start=1, enters DATA; DATA: bytes forwarded with tgt_start=0, stays DATA.
REQ-018 Forwarding latency one clk: tgt_strobe[id], tgt_din, tgt_start registered from mcu_strobe cycle; only one tgt_strobe bit high at a time.
REQ-019 Id 0 is internal system target; ids 1-3 route to tgt_strobe[1..3]; id >= 4 enters DROP, no tgt_strobe, mcu_dout=8'hFF.
REQ-020 mcu_dout updated on each mcu_strobe from tgt_dout slice of latched id (external) or internal reply (id 0); held between strobes.
REQ-021 Internal cmd 8'h00: first payload-read returns 8'hA5, subsequent reads 8'h01.
REQ-022 Internal cmd 8'h01: each payload strobe returns {4'h0, pending}.
REQ-023 Internal cmd 8'h02: first payload byte m clears pending[3:0] where m[3:0]=1 and pulses tgt_iack for those bits in the following cycle.
REQ-024 pending[n] set on rising edge of tgt_irq[n] (registered detect); set wins over simultaneous clear.
REQ-025 mcu_irq = |(pending & mask), registered.
REQ-026 Idle counter: 16-bit, cleared on every mcu_strobe, increments in CMD/DATA/DROP; reaching TIMEOUT forces IDLE, no target pulses; saturates.
REQ-027 tgt_strobe[0] never asserted (id 0 internal).

Reset
REQ-028 reset_n low: state=IDLE, mcu_dout=8'h00, mcu_irq=0, tgt_strobe=0, tgt_start=0, tgt_din=8'h00, tgt_iack=0, pending=0, mask=4'hF, counter=0, edge-detect regs=0.
REQ-029 Reset mid-frame abandons frame; first byte after release requires mcu_start=1.

Configuration
REQ-030 MCU_IRQ_MASK_EN defined: internal cmd 8'h03 first payload byte writes mask[3:0]; cmd 8'h04 returns {4'h0, mask}.
REQ-031 MCU_IRQ_MASK_EN undefined: mask constant 4'hF, cmds 8'h03/8'h04 ignored, reply 8'h00.

Structure
REQ-032 Shared package mcu_pkg: target id constants, internal command codes, state enum, version byte 8'hA5.
REQ-033 Sub-module mcu_irq_ctrl: edge detect, pending, mask, iack generation, mcu_irq.

Verification
REQ-034 Frame {8'h01 start, 8'h03, 8'h00, 8'h5A} -> tgt_strobe=4'b0010 three times, tgt_start=1 only on 8'h03, tgt_din 8'h03/8'h00/8'h5A, each one clk after mcu_strobe.
REQ-035 tgt_dout[15:8]=8'h42, frame to id 1 -> mcu_dout=8'h42 after each data strobe; frame id 7 -> mcu_dout=8'hFF, tgt_strobe stays 0.
REQ-036 tgt_irq[2] rises -> mcu_irq=1; frame {0,8'h01,x} -> reads 8'h04; frame {0,8'h02,8'h04} -> tgt_iack=4'b0100 one cycle, mcu_irq=0.
REQ-037 tgt_irq[3] rises same cycle as clear of bit 3 -> pending[3] stays 1.
REQ-038 Frame {8'h02, 8'h10} then TIMEOUT idle cycles, then non-start byte -> no tgt_strobe; with MCU_IRQ_MASK_EN, mask=4'h0 then tgt_irq[1] rise -> mcu_irq stays 0, cmd 8'h01 reads 8'h02.
REQ-039 reset_n asserted during DATA -> all outputs at REQ-028 values immediately, next non-start byte ignored.
